// File: rtl/ldo_ctrl_adaptive_if.sv
// Control/observation bundle between the LDO sequencer and the adaptive
// pass-device controller: update strobe, comparator, test override and status.
interface ldo_ctrl_adaptive_if #(
    parameter int N_PASS = 32,
    parameter int CNT_W  = 6
);
    logic              en;
    logic              comp_in;
    logic              test;
    logic [N_PASS-1:0] test_in;
    logic [N_PASS-1:0] pass_en;
    logic [CNT_W-1:0]  code;
    logic              lock;
    logic              at_max;
    logic              at_min;

    modport master (
        output en, comp_in, test, test_in,
        input  pass_en, code, lock, at_max, at_min
    );

    modport slave (
        input  en, comp_in, test, test_in,
        output pass_en, code, lock, at_max, at_min
    );
endinterface

// File: rtl/ldo_ctrl_adaptive.sv
// Adaptive digital LDO controller: comparator decisions -> thermometer pass-device word.
// Optional macro LDO_LOCK_FREEZE_EN holds code/pass_en while LOCKED.
//
// state     | meaning
// ST_FINE   | +/-1 steps, watching for long runs or sustained reversals
// ST_COARSE | +/-COARSE_STEP steps while the comparator keeps one direction
// ST_LOCKED | limit cycle detected around the target; lock asserted
module ldo_ctrl_adaptive #(
    parameter int N_PASS      = 32,
    parameter int CNT_W       = 6,
    parameter int INIT_CODE   = 16,
    parameter int COARSE_STEP = 4,
    parameter int RUN_LEN     = 3,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_RUN  = 2
) (
    input logic               clk,
    input logic               rst,
    ldo_ctrl_adaptive_if.slave bus
);
    localparam int RUN_MAX = (RUN_LEN > UNLOCK_RUN) ? RUN_LEN : UNLOCK_RUN;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int ALT_W   = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_FINE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [N_PASS-1:0] therm(input logic [CNT_W-1:0] c);
        logic [N_PASS-1:0] t;
        t = '0;
        for (int i = 0; i < N_PASS; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  code_q, code_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ALT_W-1:0]  alt_q, alt_d;
    logic              dir_q, dir_d;
    logic [N_PASS-1:0] pass_q, pass_d;
    logic              reversal;
    logic [CNT_W:0]    step;
    logic [CNT_W:0]    sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FINE;
            code_q  <= CNT_W'(INIT_CODE);
            run_q   <= '0;
            alt_q   <= '0;
            dir_q   <= 1'b0;
            pass_q  <= therm(CNT_W'(INIT_CODE));
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            run_q   <= run_d;
            alt_q   <= alt_d;
            dir_q   <= dir_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        run_d    = run_q;
        alt_d    = alt_q;
        dir_d    = dir_q;
        reversal = 1'b0;
        step     = '0;
        sum      = {1'b0, code_q};

        if (bus.en && !bus.test) begin
            dir_d = bus.comp_in;
            // run==0 only right after reset: first decision has no previous direction
            if (run_q == '0) begin
                run_d = RUN_W'(1);
            end else if (bus.comp_in == dir_q) begin
                run_d = (run_q >= RUN_W'(RUN_MAX)) ? RUN_W'(RUN_MAX) : run_q + RUN_W'(1);
                alt_d = '0;
            end else begin
                reversal = 1'b1;
                run_d    = RUN_W'(1);
                alt_d    = (alt_q >= ALT_W'(LOCK_CNT)) ? ALT_W'(LOCK_CNT) : alt_q + ALT_W'(1);
            end

            step = (state_q == ST_COARSE && !reversal) ? (CNT_W+1)'(COARSE_STEP) : (CNT_W+1)'(1);

            case (state_q)
                ST_FINE: begin
                    if (run_d >= RUN_W'(RUN_LEN))
                        state_d = ST_COARSE;
                    else if (alt_d >= ALT_W'(LOCK_CNT))
                        state_d = ST_LOCKED;
                end
                ST_COARSE: if (reversal) state_d = ST_FINE;
                ST_LOCKED: if (run_d >= RUN_W'(UNLOCK_RUN)) state_d = ST_FINE;
                default:   state_d = ST_FINE;
            endcase

            // one extra bit of headroom so the clamp sees overflow/underflow
            if (bus.comp_in) begin
                sum = {1'b0, code_q} + step;
                if (sum > (CNT_W+1)'(N_PASS))
                    sum = (CNT_W+1)'(N_PASS);
            end else begin
                if ({1'b0, code_q} < step)
                    sum = '0;
                else
                    sum = {1'b0, code_q} - step;
            end
            code_d = sum[CNT_W-1:0];
`ifdef LDO_LOCK_FREEZE_EN
            if (state_q == ST_LOCKED && state_d == ST_LOCKED)
                code_d = code_q;
`endif
        end

        pass_d = bus.test ? bus.test_in : therm(code_d);
    end

    assign bus.pass_en = pass_q;
    assign bus.code    = code_q;
    assign bus.lock    = (state_q == ST_LOCKED);
    assign bus.at_max  = (code_q == CNT_W'(N_PASS));
    assign bus.at_min  = (code_q == '0);
endmodule

// File: tb/tb_ldo_ctrl_adaptive.sv
// Scoreboard bench for ldo_ctrl_adaptive: driver runs a reference model and queues
// expected outputs; a monitor pops one entry per clock and compares.
module tb_ldo_ctrl_adaptive;
    localparam int N    = 32;
    localparam int CW   = 6;
    localparam int INIT = 16;
    localparam int CSTEP = 4;
    localparam int RLEN = 3;
    localparam int LCNT = 8;
    localparam int ULR  = 2;

    typedef struct {
        logic [CW-1:0] code;
        logic [N-1:0]  pass;
        logic          lock;
        logic          amax;
        logic          amin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    ldo_ctrl_adaptive_if #(.N_PASS(N), .CNT_W(CW)) bus ();

    ldo_ctrl_adaptive #(
        .N_PASS(N), .CNT_W(CW), .INIT_CODE(INIT), .COARSE_STEP(CSTEP),
        .RUN_LEN(RLEN), .LOCK_CNT(LCNT), .UNLOCK_RUN(ULR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int       m_code, m_run, m_alt;
    bit       m_dir, m_coarse, m_locked;
    logic [N-1:0] m_pass;

    function automatic logic [N-1:0] therm_ref(input int c);
        logic [63:0] w;
        w = (64'd1 << c) - 64'd1;
        return w[N-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit c, input bit t, input logic [N-1:0] ti);
        bit rev, was_locked, hold;
        int delta, nxt;
        if (r) begin
            m_code = INIT; m_run = 0; m_alt = 0; m_dir = 0;
            m_coarse = 0; m_locked = 0;
            m_pass = therm_ref(INIT);
            return;
        end
        if (e && !t) begin
            rev = (m_run > 0) && (c != m_dir);
            if (m_run == 0) m_run = 1;
            else if (rev) begin
                m_run = 1;
                m_alt = (m_alt + 1 > LCNT) ? LCNT : m_alt + 1;
            end else begin
                m_run = (m_run + 1 > ((RLEN > ULR) ? RLEN : ULR)) ? ((RLEN > ULR) ? RLEN : ULR) : m_run + 1;
                m_alt = 0;
            end
            m_dir = c;
            delta = (m_coarse && !rev) ? CSTEP : 1;
            was_locked = m_locked;
            if (m_coarse) begin
                if (rev) m_coarse = 0;
            end else if (m_locked) begin
                if (m_run >= ULR) m_locked = 0;
            end else if (m_run >= RLEN) m_coarse = 1;
            else if (m_alt >= LCNT) m_locked = 1;
`ifdef LDO_LOCK_FREEZE_EN
            hold = was_locked && m_locked;
`else
            hold = 0;
`endif
            if (!hold) begin
                nxt = c ? m_code + delta : m_code - delta;
                m_code = (nxt > N) ? N : (nxt < 0) ? 0 : nxt;
            end
        end
        m_pass = t ? ti : therm_ref(m_code);
    endtask

    task automatic cyc(input bit r, input bit e, input bit c, input bit t, input logic [N-1:0] ti);
        exp_t x;
        @(negedge clk);
        rst = r; bus.en = e; bus.comp_in = c; bus.test = t; bus.test_in = ti;
        model_edge(r, e, c, t, ti);
        x.code = CW'(m_code);
        x.pass = m_pass;
        x.lock = m_locked;
        x.amax = (m_code == N);
        x.amin = (m_code == 0);
        sb.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("code",    32'(bus.code),   32'(x.code));
            check("pass_en", bus.pass_en,     x.pass);
            check("lock",    32'(bus.lock),   32'(x.lock));
            check("at_max",  32'(bus.at_max), 32'(x.amax));
            check("at_min",  32'(bus.at_min), 32'(x.amin));
        end
    end

    initial begin
        bit c_prev;
        bit r, e, c, t;
        rst = 1'b1; bus.en = 0; bus.comp_in = 0; bus.test = 0; bus.test_in = '0;

        // reset defaults
        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        settle();
        check("reset_code", 32'(bus.code), 32'd16);
        check("reset_pass", bus.pass_en, 32'h0000FFFF);
        check("reset_lock", 32'(bus.lock), 32'd0);

        // coarse ramp to the ceiling
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, '0);
        settle();
        check("ramp_code", 32'(bus.code), 32'd32);
        check("ramp_pass", bus.pass_en, 32'hFFFFFFFF);
        check("ramp_at_max", 32'(bus.at_max), 32'd1);

        // coarse-to-fine reversal
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, '0);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        settle();
        check("reversal_code", 32'(bus.code), 32'd25);

        // limit cycle lock, then unlock with two ups
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 9; i++) cyc(0, 1, (i % 2 == 0), 0, '0);
        settle();
        check("lock_set", 32'(bus.lock), 32'd1);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 1, 0, '0);
        cyc(0, 1, 1, 0, '0);
        settle();
        check("unlock_lock", 32'(bus.lock), 32'd0);
        check("unlock_code", 32'(bus.code), 32'd18);

        // test override
        for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 1, 32'hA5A5A5A5);
        settle();
        check("test_pass", bus.pass_en, 32'hA5A5A5A5);
        check("test_code", 32'(bus.code), 32'd18);
        cyc(0, 0, 0, 0, '0);
        settle();
        check("test_exit_pass", bus.pass_en, 32'h0003FFFF);

        // floor and en gating
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 0, i[0], 0, '0);
        settle();
        check("floor_code", 32'(bus.code), 32'd0);
        check("floor_at_min", 32'(bus.at_min), 32'd1);

        // random: mostly-alternating phase, then mostly-same-direction phase
        c_prev = 0;
        for (int ph = 0; ph < 2; ph++) begin
            cyc(1, 0, 0, 0, '0);
            for (int i = 0; i < 250; i++) begin
                r = ($urandom_range(0, 99) < 2);
                e = ($urandom_range(0, 99) < 75);
                t = ($urandom_range(0, 99) < 8);
                if (ph == 0) c = ($urandom_range(0, 99) < 80) ? ~c_prev : c_prev;
                else         c = ($urandom_range(0, 99) < 80) ? c_prev : ~c_prev;
                if (e) c_prev = c;
                cyc(r, e, c, t, N'($urandom));
            end
        end

        settle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
